// File: rtl/oam_dma_arbiter_if.sv
// Bus bundle between the cpu core, the sprite DMA arbiter and the system bus decoder.
// The arbiter takes the slave view; whoever drives the core and memory side takes master.
interface oam_dma_arbiter_if;
  logic        tick;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        dma_busy;

  modport master (
    output tick, cpu_addr, cpu_wdata, cpu_read, cpu_write, bus_rdata,
    input  cpu_en, bus_addr, bus_wdata, bus_read, bus_write, dma_busy
  );

  modport slave (
    input  tick, cpu_addr, cpu_wdata, cpu_read, cpu_write, bus_rdata,
    output cpu_en, bus_addr, bus_wdata, bus_read, bus_write, dma_busy
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Shares the cpu bus between the core and the 256-byte sprite (OAM) DMA copy.
// The core is frozen through cpu_en while the copy owns the bus.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | core owns the bus, bus_* mirror cpu_*
// HALT  | dummy cycle after the trigger write, strobes off
// ALIGN | extra idle cycle so that every READ lands on a GET (parity 0) cycle
// READ  | fetch source byte {page,idx} into dma_data
// WRITE | store dma_data to OAM_DATA_ADDR, advance idx, finish after idx FF
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic             clk,
  input  logic             reset,
  oam_dma_arbiter_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state, state_nxt;
  logic       parity;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] dma_data, dma_data_nxt;

  // Everything, parity included, advances only on cpu-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      parity   <= 1'b0;
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_data <= 8'h00;
    end else if (io.tick) begin
      state    <= state_nxt;
      parity   <= ~parity;
      page     <= page_nxt;
      idx      <= idx_nxt;
      dma_data <= dma_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    page_nxt     = page;
    idx_nxt      = idx;
    dma_data_nxt = dma_data;
    io.bus_addr  = io.cpu_addr;
    io.bus_wdata = io.cpu_wdata;
    io.bus_read  = io.cpu_read;
    io.bus_write = io.cpu_write;

    case (state)
      S_IDLE: begin
        // The trigger write itself still goes out to the bus this cycle.
        if (io.cpu_write && (io.cpu_addr == TRIGGER_ADDR)) begin
          state_nxt = S_HALT;
          page_nxt  = io.cpu_wdata;
          idx_nxt   = 8'h00;
        end
      end
      S_HALT: begin
        io.bus_wdata = dma_data;
        io.bus_read  = 1'b0;
        io.bus_write = 1'b0;
        state_nxt    = parity ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        io.bus_addr  = {page, idx};
        io.bus_wdata = dma_data;
        io.bus_read  = 1'b0;
        io.bus_write = 1'b0;
        state_nxt    = S_READ;
      end
      S_READ: begin
        io.bus_addr  = {page, idx};
        io.bus_wdata = dma_data;
        io.bus_read  = 1'b1;
        io.bus_write = 1'b0;
        dma_data_nxt = io.bus_rdata;
        state_nxt    = S_WRITE;
      end
      S_WRITE: begin
        io.bus_addr  = OAM_DATA_ADDR;
        io.bus_wdata = dma_data;
        io.bus_read  = 1'b0;
        io.bus_write = 1'b1;
        // idx wraps inside the page, so the source never carries into the page byte.
        idx_nxt      = idx + 8'd1;
        state_nxt    = (idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign io.dma_busy = (state != S_IDLE);
  assign io.cpu_en   = io.tick & (state == S_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: passthrough vector table plus full DMA sequences
// covering alignment, tick gating, reset mid-copy and page FF.
module tb_oam_dma_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_arbiter_if ifc ();

  oam_dma_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc.slave)
  );

  int errors = 0;
  int checks = 0;
  bit tb_par = 1'b0;

  // Memory image: page 02 holds 00..FF in order.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'h02);
  endfunction

  always_comb ifc.bus_rdata = mem_val(ifc.bus_addr);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
    ifc.cpu_addr  = a;
    ifc.cpu_wdata = d;
    ifc.cpu_read  = rd;
    ifc.cpu_write = wr;
  endtask

  task automatic apply(input logic t);
    ifc.tick = t;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (ifc.tick && !reset) tb_par = ~tb_par;
  endtask

  task automatic pre_gap(input int gap);
    for (int k = 1; k < gap; k++) begin
      apply(1'b0);
      chk("gap_cpu_en", {15'd0, ifc.cpu_en}, 16'd0);
      advance();
    end
  endtask

  task automatic idle_tick(input int gap);
    set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
    pre_gap(gap);
    apply(1'b1);
    chk("idle_busy", {15'd0, ifc.dma_busy}, 16'd0);
    advance();
  endtask

  task automatic run_dma(input logic [7:0] pg, input int gap, input bit halt_par, input int abort_after);
    int stalled;
    stalled = 0;
    // HALT parity is the inverse of the trigger tick's parity.
    if (tb_par == halt_par) idle_tick(gap);

    set_cpu(16'h4014, pg, 1'b0, 1'b1);
    pre_gap(gap);
    apply(1'b1);
    chk("trig_bus_write", {15'd0, ifc.bus_write}, 16'd1);
    chk("trig_bus_addr", ifc.bus_addr, 16'h4014);
    chk("trig_bus_wdata", {8'd0, ifc.bus_wdata}, {8'd0, pg});
    chk("trig_cpu_en", {15'd0, ifc.cpu_en}, 16'd1);
    advance();

    // Frozen core keeps presenting a read; the arbiter must ignore it.
    set_cpu(16'h4014, 8'hA5, 1'b1, 1'b0);
    pre_gap(gap);
    apply(1'b1);
    chk("halt_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd0);
    chk("halt_busy", {15'd0, ifc.dma_busy}, 16'd1);
    if (ifc.cpu_en === 1'b0) stalled++;
    advance();

    if (!halt_par) begin
      pre_gap(gap);
      apply(1'b1);
      chk("align_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd0);
      chk("align_busy", {15'd0, ifc.dma_busy}, 16'd1);
      if (ifc.cpu_en === 1'b0) stalled++;
      advance();
    end

    for (int i = 0; i < 256; i++) begin
      pre_gap(gap);
      apply(1'b1);
      chk("read_addr", ifc.bus_addr, {pg, i[7:0]});
      chk("read_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd2);
      chk("read_par", {15'd0, tb_par}, 16'd0);
      chk("read_busy", {15'd0, ifc.dma_busy}, 16'd1);
      if (ifc.cpu_en === 1'b0) stalled++;
      advance();

      pre_gap(gap);
      apply(1'b1);
      chk("write_addr", ifc.bus_addr, 16'h2004);
      chk("write_data", {8'd0, ifc.bus_wdata}, {8'd0, mem_val({pg, i[7:0]})});
      chk("write_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd1);
      chk("write_busy", {15'd0, ifc.dma_busy}, 16'd1);
      if (ifc.cpu_en === 1'b0) stalled++;
      advance();

      if (i == abort_after) begin
        set_cpu(16'h1234, 8'h5A, 1'b0, 1'b1);
        ifc.tick = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_busy", {15'd0, ifc.dma_busy}, 16'd0);
        chk("rst_cpu_en", {15'd0, ifc.cpu_en}, 16'd1);
        chk("rst_bus_addr", ifc.bus_addr, 16'h1234);
        chk("rst_bus_wdata", {8'd0, ifc.bus_wdata}, 16'h005A);
        chk("rst_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd1);
        @(posedge clk);
        #1;
        set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        tb_par = 1'b0;
        return;
      end
    end

    set_cpu(16'h0300, 8'h11, 1'b1, 1'b0);
    pre_gap(gap);
    apply(1'b1);
    chk("done_cpu_en", {15'd0, ifc.cpu_en}, 16'd1);
    chk("done_busy", {15'd0, ifc.dma_busy}, 16'd0);
    chk("done_bus_addr", ifc.bus_addr, 16'h0300);
    chk("done_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd2);
    chk("stall_ticks", stalled[15:0], halt_par ? 16'd513 : 16'd514);
    advance();
  endtask

  typedef struct {
    logic        tk;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd;
    logic        wr;
    logic        exp_en;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 16'h4015, 8'h02, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 16'h4013, 8'h02, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h4014, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h4014, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h4015, 8'h33, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 16'h0200, 8'h44, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h2004, 8'h55, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'hFFFF, 8'hEE, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    ifc.tick = 1'b1;
    set_cpu(16'hBEEF, 8'h3C, 1'b1, 1'b0);
    #2;
    chk("reset_busy", {15'd0, ifc.dma_busy}, 16'd0);
    chk("reset_cpu_en", {15'd0, ifc.cpu_en}, 16'd1);
    chk("reset_bus_addr", ifc.bus_addr, 16'hBEEF);
    chk("reset_bus_wdata", {8'd0, ifc.bus_wdata}, 16'h003C);
    chk("reset_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, 16'd2);
    @(posedge clk);
    #1;
    set_cpu(16'h0000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tb_par = 1'b0;

    foreach (vecs[n]) begin
      set_cpu(vecs[n].a, vecs[n].d, vecs[n].rd, vecs[n].wr);
      apply(vecs[n].tk);
      chk("vec_cpu_en", {15'd0, ifc.cpu_en}, {15'd0, vecs[n].exp_en});
      chk("vec_busy", {15'd0, ifc.dma_busy}, 16'd0);
      chk("vec_bus_addr", ifc.bus_addr, vecs[n].a);
      chk("vec_bus_wdata", {8'd0, ifc.bus_wdata}, {8'd0, vecs[n].d});
      chk("vec_strobes", {14'd0, ifc.bus_read, ifc.bus_write}, {14'd0, vecs[n].rd, vecs[n].wr});
      advance();
    end

    run_dma(8'h02, 1, 1'b1, -1);
    run_dma(8'h02, 1, 1'b0, -1);
    run_dma(8'h05, 3, 1'b1, -1);
    run_dma(8'h02, 1, 1'b0, 99);
    run_dma(8'h03, 1, 1'b1, -1);
    run_dma(8'hFF, 1, 1'b0, -1);
    idle_tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
